// File: rtl/web_pkg.sv
// Shared types, cost tables and adder-subtractor helpers for the web-shooter fire path.
package web_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CHECK    = 3'd1,
        DEBIT    = 3'd2,
        RESP     = 3'd3,
        WAIT_LOW = 3'd4
    } web_state_e;

    localparam int WEB_T0 = 0;
    localparam int WEB_T1 = 1;
    localparam int WEB_T2 = 2;
    localparam int WEB_T3 = 3;
    localparam int WEB_T4 = 4;
    localparam int WEB_T5 = 5;
    localparam int WEB_T6 = 6;
    localparam int WEB_T7 = 7;
    localparam int REFILL_IDX = WEB_T7;

    localparam logic [7:0] E_COST [8] = '{8'd4, 8'd8, 8'd12, 8'd16, 8'd20, 8'd24, 8'd32, 8'd40};
    localparam logic [5:0] T_COST [8] = '{6'd0, 6'd0, 6'd0, 6'd1, 6'd1, 6'd2, 6'd2, 6'd0};
    localparam logic [3:0] F_COST [8] = '{4'd1, 4'd1, 4'd2, 4'd2, 4'd3, 4'd3, 4'd4, 4'd0};

    // Ripple adder-subtractors: sub=1 gives a + ~b + 1, i.e. a - b.
    function automatic logic [7:0] addsub8(input logic [7:0] a, input logic [7:0] b, input logic sub);
        return a + (sub ? ~b : b) + {7'd0, sub};
    endfunction

    function automatic logic [5:0] addsub6(input logic [5:0] a, input logic [5:0] b, input logic sub);
        return a + (sub ? ~b : b) + {5'd0, sub};
    endfunction

    function automatic logic [3:0] addsub4(input logic [3:0] a, input logic [3:0] b, input logic sub);
        return a + (sub ? ~b : b) + {3'd0, sub};
    endfunction

endpackage

// File: rtl/web_fire_controller_if.sv
// Fire-request handshake plus the resource-register load/enable bus.
interface web_fire_controller_if;
    logic       fire_req;
    logic [7:0] web_onehot;
    logic [7:0] energy_q;
    logic [5:0] tracer_q;
    logic [3:0] fluid_q;
    logic [7:0] energy_load;
    logic       energy_en;
    logic [5:0] tracer_load;
    logic       tracer_en;
    logic [3:0] fluid_load;
    logic       fluid_en;
    logic       fire_ack;
    logic       fire_ok;
    logic       busy;

    modport master (
        output fire_req, web_onehot, energy_q, tracer_q, fluid_q,
        input  energy_load, energy_en, tracer_load, tracer_en, fluid_load, fluid_en,
        input  fire_ack, fire_ok, busy
    );

    modport slave (
        input  fire_req, web_onehot, energy_q, tracer_q, fluid_q,
        output energy_load, energy_en, tracer_load, tracer_en, fluid_load, fluid_en,
        output fire_ack, fire_ok, busy
    );
endinterface

// File: rtl/web_cost_lookup.sv
// Combinational one-hot web type to resource cost decoder, shared with HUD logic.
module web_cost_lookup
    import web_pkg::*;
(
    input  logic [7:0] web_onehot,
    output logic [7:0] e_cost,
    output logic [5:0] t_cost,
    output logic [3:0] f_cost,
    output logic       valid,
    output logic       refill
);

    logic [2:0] sel_s;

    // Decode the select; anything other than exactly one set bit is invalid.
    always_comb begin
        sel_s = 3'd0;
        valid = 1'b0;
        case (web_onehot)
            8'h01:   begin sel_s = 3'(WEB_T0); valid = 1'b1; end
            8'h02:   begin sel_s = 3'(WEB_T1); valid = 1'b1; end
            8'h04:   begin sel_s = 3'(WEB_T2); valid = 1'b1; end
            8'h08:   begin sel_s = 3'(WEB_T3); valid = 1'b1; end
            8'h10:   begin sel_s = 3'(WEB_T4); valid = 1'b1; end
            8'h20:   begin sel_s = 3'(WEB_T5); valid = 1'b1; end
            8'h40:   begin sel_s = 3'(WEB_T6); valid = 1'b1; end
            8'h80:   begin sel_s = 3'(WEB_T7); valid = 1'b1; end
            default: begin sel_s = 3'd0;      valid = 1'b0; end
        endcase
    end

    // Invalid selections report zero cost so nothing downstream can act on them.
    always_comb begin
        e_cost = 8'd0;
        t_cost = 6'd0;
        f_cost = 4'd0;
        refill = 1'b0;
        if (valid) begin
            e_cost = E_COST[sel_s];
            t_cost = T_COST[sel_s];
            f_cost = F_COST[sel_s];
            refill = (sel_s == 3'(REFILL_IDX));
        end else begin
            refill = 1'b0;
        end
    end

endmodule

// File: rtl/web_fire_controller.sv
// Fire sequencer: checks resource cost for the requested web, debits or denies,
// and trickle-recharges energy while idle.
module web_fire_controller
    import web_pkg::*;
#(
    parameter int RECHARGE_PERIOD = 16,
    parameter int ENERGY_MAX      = 255,
    parameter int FLUID_MAX       = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    web_fire_controller_if.slave  bus
);

    localparam int              CNT_W    = $clog2(RECHARGE_PERIOD);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RECHARGE_PERIOD - 1);
    localparam logic [7:0]      E_MAX_C  = 8'(ENERGY_MAX);
    localparam logic [3:0]      F_MAX_C  = 4'(FLUID_MAX);

    web_state_e       state_r;
    logic [7:0]       web_r;
    logic [CNT_W-1:0] cnt_r;
    logic             ok_r;
    logic [7:0]       energy_load_r;
    logic             energy_en_r;
    logic [5:0]       tracer_load_r;
    logic             tracer_en_r;
    logic [3:0]       fluid_load_r;
    logic             fluid_en_r;
    logic             fire_ack_r;
    logic             fire_ok_r;
    logic             busy_r;

    logic [7:0] e_cost_s;
    logic [5:0] t_cost_s;
    logic [3:0] f_cost_s;
    logic       valid_s;
    logic       refill_s;
    logic       ok_s;

    web_cost_lookup u_cost_lookup (
        .web_onehot (web_r),
        .e_cost     (e_cost_s),
        .t_cost     (t_cost_s),
        .f_cost     (f_cost_s),
        .valid      (valid_s),
        .refill     (refill_s)
    );

    assign ok_s = valid_s
                  && (bus.energy_q >= e_cost_s)
                  && (bus.tracer_q >= t_cost_s)
                  && (bus.fluid_q  >= f_cost_s);

    // Main sequencer; enables, ack and ok are single-cycle strobes defaulting low.
    // A deny still spends the DEBIT slot (with no enables) so both outcomes ack at the same latency.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= IDLE;
            web_r         <= 8'd0;
            cnt_r         <= {CNT_W{1'b0}};
            ok_r          <= 1'b0;
            energy_load_r <= 8'd0;
            energy_en_r   <= 1'b0;
            tracer_load_r <= 6'd0;
            tracer_en_r   <= 1'b0;
            fluid_load_r  <= 4'd0;
            fluid_en_r    <= 1'b0;
            fire_ack_r    <= 1'b0;
            fire_ok_r     <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            energy_load_r <= 8'd0;
            energy_en_r   <= 1'b0;
            tracer_load_r <= 6'd0;
            tracer_en_r   <= 1'b0;
            fluid_load_r  <= 4'd0;
            fluid_en_r    <= 1'b0;
            fire_ack_r    <= 1'b0;
            fire_ok_r     <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.fire_req) begin
                        web_r   <= bus.web_onehot;
                        state_r <= CHECK;
                        busy_r  <= 1'b1;
                    end else if (cnt_r == CNT_LAST) begin
                        cnt_r <= {CNT_W{1'b0}};
                        if (bus.energy_q < E_MAX_C) begin
                            energy_en_r   <= 1'b1;
                            energy_load_r <= addsub8(bus.energy_q, 8'd1, 1'b0);
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                CHECK: begin
                    ok_r    <= ok_s;
                    state_r <= DEBIT;
                    if (ok_s) begin
                        energy_en_r   <= 1'b1;
                        tracer_en_r   <= 1'b1;
                        fluid_en_r    <= 1'b1;
                        energy_load_r <= addsub8(bus.energy_q, e_cost_s, 1'b1);
                        tracer_load_r <= addsub6(bus.tracer_q, t_cost_s, 1'b1);
                        fluid_load_r  <= refill_s ? F_MAX_C : addsub4(bus.fluid_q, f_cost_s, 1'b1);
                    end
                end
                DEBIT: begin
                    fire_ack_r <= 1'b1;
                    fire_ok_r  <= ok_r;
                    state_r    <= RESP;
                end
                RESP: begin
                    cnt_r   <= {CNT_W{1'b0}};
                    state_r <= WAIT_LOW;
                end
                WAIT_LOW: begin
                    if (!bus.fire_req) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.energy_load = energy_load_r;
    assign bus.energy_en   = energy_en_r;
    assign bus.tracer_load = tracer_load_r;
    assign bus.tracer_en   = tracer_en_r;
    assign bus.fluid_load  = fluid_load_r;
    assign bus.fluid_en    = fluid_en_r;
    assign bus.fire_ack    = fire_ack_r;
    assign bus.fire_ok     = fire_ok_r;
    assign bus.busy        = busy_r;

endmodule

// File: tb/tb_web_fire_controller.sv
// Directed bench for web_fire_controller with a behavioural model of the three resource registers.
module tb_web_fire_controller;
    import web_pkg::*;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    web_fire_controller_if bus_if ();

    web_fire_controller #(
        .RECHARGE_PERIOD (16),
        .ENERGY_MAX      (255),
        .FLUID_MAX       (15)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock; the register model writes back whatever enables were visible before the edge.
    task automatic cyc();
        logic       ee, te, fe;
        logic [7:0] el;
        logic [5:0] tl;
        logic [3:0] fl;
        ee = bus_if.energy_en;  el = bus_if.energy_load;
        te = bus_if.tracer_en;  tl = bus_if.tracer_load;
        fe = bus_if.fluid_en;   fl = bus_if.fluid_load;
        @(posedge clk);
        #1;
        if (ee) bus_if.energy_q = el;
        if (te) bus_if.tracer_q = tl;
        if (fe) bus_if.fluid_q  = fl;
    endtask

    task automatic set_regs(input logic [7:0] e, input logic [5:0] t, input logic [3:0] f);
        bus_if.energy_q = e;
        bus_if.tracer_q = t;
        bus_if.fluid_q  = f;
    endtask

    task automatic do_fire(input string tag, input logic [7:0] web, input logic ok_exp,
                           input logic [7:0] el, input logic [5:0] tl, input logic [3:0] fl,
                           input int hold);
        bus_if.web_onehot = web;
        bus_if.fire_req   = 1'b1;
        cyc();
        chk({tag, "/check_busy"}, 32'(bus_if.busy), 32'd1);
        chk({tag, "/check_noen"}, 32'({bus_if.energy_en, bus_if.tracer_en, bus_if.fluid_en}), 32'd0);
        cyc();
        chk({tag, "/debit_en"}, 32'({bus_if.energy_en, bus_if.tracer_en, bus_if.fluid_en}),
            32'({ok_exp, ok_exp, ok_exp}));
        chk({tag, "/debit_load"}, 32'({bus_if.energy_load, bus_if.tracer_load, bus_if.fluid_load}),
            32'({el, tl, fl}));
        chk({tag, "/debit_noack"}, 32'(bus_if.fire_ack), 32'd0);
        cyc();
        chk({tag, "/ack"}, 32'({bus_if.fire_ack, bus_if.fire_ok}), 32'({1'b1, ok_exp}));
        chk({tag, "/resp_noen"}, 32'({bus_if.energy_en, bus_if.tracer_en, bus_if.fluid_en}), 32'd0);
        for (int i = 0; i < hold; i++) begin
            cyc();
            chk({tag, "/wait_hold"}, 32'({bus_if.fire_ack, bus_if.busy, bus_if.energy_en,
                                          bus_if.tracer_en, bus_if.fluid_en}), 32'b01000);
        end
        bus_if.fire_req = 1'b0;
        cyc();
        chk({tag, "/idle"}, 32'({bus_if.busy, bus_if.fire_ack}), 32'd0);
    endtask

    task automatic chk_all_low(input string tag);
        chk({tag, "/en"}, 32'({bus_if.energy_en, bus_if.tracer_en, bus_if.fluid_en}), 32'd0);
        chk({tag, "/load"}, 32'({bus_if.energy_load, bus_if.tracer_load, bus_if.fluid_load}), 32'd0);
        chk({tag, "/ack_ok_busy"}, 32'({bus_if.fire_ack, bus_if.fire_ok, bus_if.busy}), 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        bus_if.fire_req   = 1'b0;
        bus_if.web_onehot = 8'd0;
        set_regs(8'd0, 6'd0, 4'd0);

        // Reset state
        cyc();
        chk_all_low("reset");
        chk("reset/state", 32'(dut.state_r), 32'(IDLE));
        reset = 1'b1;

        // Normal fire, t3
        set_regs(8'd100, 6'd10, 4'd8);
        do_fire("t3_ok", 8'h08, 1'b1, 8'd84, 6'd9, 4'd6, 1);
        // Tracer short
        set_regs(8'd100, 6'd0, 4'd8);
        do_fire("t3_short", 8'h08, 1'b0, 8'd0, 6'd0, 4'd0, 1);
        // Bad selects
        set_regs(8'd100, 6'd10, 4'd8);
        do_fire("sel_zero", 8'h00, 1'b0, 8'd0, 6'd0, 4'd0, 1);
        do_fire("sel_two", 8'h03, 1'b0, 8'd0, 6'd0, 4'd0, 1);
        // Refill: tracer has zero cost but is still written
        set_regs(8'd50, 6'd5, 4'd2);
        do_fire("refill", 8'h80, 1'b1, 8'd10, 6'd5, 4'd15, 1);
        // Exact-cost boundary and one-short
        set_regs(8'd32, 6'd2, 4'd4);
        do_fire("t6_exact", 8'h40, 1'b1, 8'd0, 6'd0, 4'd0, 1);
        set_regs(8'd31, 6'd2, 4'd4);
        do_fire("t6_short", 8'h40, 1'b0, 8'd0, 6'd0, 4'd0, 1);

        // Recharge: one pulse to 255, then saturation
        set_regs(8'd254, 6'd10, 4'd8);
        for (int i = 0; i < 48; i++) begin
            cyc();
            chk("recharge/en", 32'(bus_if.energy_en), (i == 15) ? 32'd1 : 32'd0);
            chk("recharge/load", 32'(bus_if.energy_load), (i == 15) ? 32'd255 : 32'd0);
        end
        chk("recharge/final_energy", 32'(bus_if.energy_q), 32'd255);

        // Request lands on the tick cycle: no pulse, counter restarts after ack
        set_regs(8'd100, 6'd10, 4'd8);
        for (int i = 0; i < 15; i++) begin
            cyc();
        end
        chk("tick/pre_en", 32'(bus_if.energy_en), 32'd0);
        do_fire("tick_fire", 8'h01, 1'b1, 8'd96, 6'd10, 4'd7, 1);
        for (int i = 0; i < 16; i++) begin
            cyc();
            chk("tick/restart_en", 32'(bus_if.energy_en), (i == 15) ? 32'd1 : 32'd0);
        end
        chk("tick/restart_load", 32'(bus_if.energy_load), 32'd97);
        cyc();

        // Reset in the middle of DEBIT
        set_regs(8'd100, 6'd10, 4'd8);
        bus_if.web_onehot = 8'h01;
        bus_if.fire_req   = 1'b1;
        cyc();
        cyc();
        chk("rst_mid/debit_en", 32'({bus_if.energy_en, bus_if.tracer_en, bus_if.fluid_en}), 32'b111);
        #2;
        reset = 1'b0;
        #1;
        chk_all_low("rst_mid");
        chk("rst_mid/state", 32'(dut.state_r), 32'(IDLE));
        bus_if.fire_req = 1'b0;
        cyc();
        chk_all_low("rst_hold");
        chk("rst_hold/energy_kept", 32'(bus_if.energy_q), 32'd100);
        reset = 1'b1;

        // Request held well past ack: one ack only
        do_fire("hold", 8'h02, 1'b1, 8'd92, 6'd10, 4'd7, 6);
        cyc();
        chk("hold/no_refire", 32'({bus_if.busy, bus_if.fire_ack}), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
